// File: rtl/binary_search_main_pkg.sv
// Shared types, sizes and reset contents for the binary-search kernel.
package binary_search_main_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StReq,
        StWait,
        StCmp,
        StWr,
        StDone
    } state_e;

    localparam int unsigned Depth      = 8;
    localparam int unsigned WordW      = 32;

    // Offsets of the search key and result word from the value-table base.
    localparam int unsigned KeyOffset  = 32;
    localparam int unsigned ResOffset  = 36;

    // Internal byte store: key table first, then value table, search key, result.
    localparam int unsigned KeyBytes   = Depth * 4;
    localparam int unsigned ValBytes   = ResOffset + 4;
    localparam int unsigned MemBytes   = KeyBytes + ValBytes;
    localparam int unsigned MemWords   = MemBytes / 4;

    // Word indices into the internal store.
    localparam logic [4:0] ValWord     = 5'(Depth);
    localparam logic [4:0] SkeyWord    = 5'((KeyBytes + KeyOffset) / 4);
    localparam logic [4:0] ResWord     = 5'((KeyBytes + ResOffset) / 4);

    localparam int unsigned KeyStep    = 10;
    localparam int unsigned ValFirst   = 100;
    localparam int unsigned DefaultKey = 50;

    localparam logic [WordW-1:0] MissWord = '1;

    // Reset value of byte idx of the internal store (little-endian words).
    function automatic logic [7:0] reset_byte(input int idx);
        int          w;
        logic [31:0] v;
        w = idx / 4;
        if (w < int'(Depth)) begin
            v = 32'(KeyStep * (w + 1));
        end else if (w < int'(2 * Depth)) begin
            v = 32'(ValFirst + w - Depth);
        end else if (w == int'(2 * Depth)) begin
            v = 32'(DefaultKey);
        end else begin
            v = '0;
        end
        return 8'(v >> (8 * (idx % 4)));
    endfunction

endpackage

// File: rtl/binary_search_main_bs_mem.sv
// Register-based byte memory: two byte-wide slave ports with a read delay
// pipeline, plus one 32-bit internal read port and one 32-bit write port.
module bs_mem
    import binary_search_main_pkg::*;
#(
    parameter int unsigned KeyBase = 32,
    parameter int unsigned ValBase = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_slave_en,
    input  logic [1:0]  i_oe,
    input  logic [1:0]  i_we,
    input  logic [13:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic [1:0]  o_rdy,
    input  logic [4:0]  i_rd_word,
    output logic [31:0] o_rd_data,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_word,
    input  logic [31:0] i_wr_data
);

    localparam int unsigned KeyEnd = KeyBase + KeyBytes;
    localparam int unsigned ValEnd = ValBase + ValBytes;

    logic [7:0]       r_mem [MemBytes];
    logic [1:0]       w_hit;
    logic [1:0][6:0]  w_idx;
    logic [1:0][7:0]  w_rbyte;
    logic [6:0]       w_rd_base;
    logic [6:0]       w_wr_base;

    logic [1:0]       r_rd_p1;
    logic [1:0]       r_rd_p2;
    logic [1:0]       r_wr_p1;
    logic [15:0]      r_rd_b1;
    logic [15:0]      r_rd_b2;
    logic [15:0]      r_rdata;
    logic [1:0]       r_rdy;

    // Map a bus byte address to {hit, store index}.
    function automatic logic [7:0] decode(input logic [6:0] a);
        int unsigned ua;
        ua = 32'(a);
        if (ua >= KeyBase && ua < KeyEnd) begin
            return {1'b1, 7'(ua - KeyBase)};
        end else if (ua >= ValBase && ua < ValEnd) begin
            return {1'b1, 7'(ua - ValBase + KeyBytes)};
        end
        return 8'h00;
    endfunction

    // Per-channel address decode and combinational byte fetch.
    always_comb begin
        w_hit   = '0;
        w_idx   = '0;
        w_rbyte = '0;
        for (int c = 0; c < 2; c++) begin
            {w_hit[c], w_idx[c]} = decode(i_addr[7*c +: 7]);
            if (w_hit[c]) begin
                w_rbyte[c] = r_mem[w_idx[c]];
            end
        end
    end

    assign w_rd_base = {i_rd_word, 2'b00};
    assign w_wr_base = {i_wr_word, 2'b00};

    // Internal word read, asynchronous; out-of-store words read as zero.
    always_comb begin
        o_rd_data = '0;
        if (32'(i_rd_word) < MemWords) begin
            o_rd_data = {r_mem[w_rd_base + 7'd3], r_mem[w_rd_base + 7'd2],
                         r_mem[w_rd_base + 7'd1], r_mem[w_rd_base]};
        end
    end

    // Storage update; channel 1 is applied last so it wins a byte collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(MemBytes); i++) begin
                r_mem[7'(i)] <= reset_byte(i);
            end
        end else begin
            if (i_wr_en && 32'(i_wr_word) < MemWords) begin
                for (int b = 0; b < 4; b++) begin
                    r_mem[w_wr_base + 7'(b)] <= i_wr_data[8*b +: 8];
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (i_slave_en && i_we[c] && w_hit[c]) begin
                    r_mem[w_idx[c]] <= i_wdata[8*c +: 8];
                end
            end
        end
    end

    // Slave handshake pipeline: reads complete two edges after sampling, writes one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_p1 <= '0;
            r_rd_p2 <= '0;
            r_wr_p1 <= '0;
            r_rd_b1 <= '0;
            r_rd_b2 <= '0;
            r_rdata <= '0;
            r_rdy   <= '0;
        end else begin
            r_wr_p1 <= i_we & {2{i_slave_en}};
            r_rd_p1 <= i_oe & ~i_we & {2{i_slave_en}};
            r_rd_b1 <= w_rbyte;
            r_rd_p2 <= r_rd_p1;
            r_rd_b2 <= r_rd_b1;
            r_rdy   <= r_rd_p2 | r_wr_p1;
            for (int c = 0; c < 2; c++) begin
                if (r_rd_p2[c]) begin
                    r_rdata[8*c +: 8] <= r_rd_b2[8*c +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_rdy   = r_rdy;

endmodule

// File: rtl/binary_search_main.sv
// Binary-search kernel: searches the key table for the search key and writes
// the matching value (or all-ones on a miss) to the result word.
module binary_search_main
    import binary_search_main_pkg::*;
#(
    parameter int unsigned MEM_var_28859_28865 = 32,
    parameter int unsigned MEM_var_28861_28865 = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy
);

    state_e                  r_state;
    logic signed [4:0]       r_lo;
    logic signed [4:0]       r_hi;
    logic signed [4:0]       r_mid;
    logic signed [WordW-1:0] r_skey;
    logic signed [WordW-1:0] r_key_mid;
    logic [WordW-1:0]        r_res_word;
    logic                    r_done;

    logic signed [4:0]       w_sum;
    logic signed [4:0]       w_mid;
    logic signed [4:0]       w_lo_nxt;
    logic signed [4:0]       w_hi_nxt;
    logic                    w_key_lt;
    logic                    w_key_eq;
    logic                    w_miss;
    logic [4:0]              w_rd_word;
    logic [WordW-1:0]        w_rd_data;
    logic                    w_wr_en;
    logic                    w_slave_en;
    logic                    w_unused_size;

    // Access size is always treated as a byte.
    assign w_unused_size = ^S_data_ram_size;

    assign w_sum    = r_lo + r_hi;
    assign w_mid    = w_sum >>> 1;
    assign w_key_lt = r_key_mid < r_skey;
    assign w_key_eq = r_key_mid == r_skey;
    assign w_lo_nxt = w_key_lt ? r_mid + 5'sd1 : r_lo;
    assign w_hi_nxt = w_key_lt ? r_hi : r_mid - 5'sd1;
    assign w_miss   = w_lo_nxt > w_hi_nxt;

    assign w_wr_en    = (r_state == StWr);
    assign w_slave_en = (r_state == StIdle);

    // Internal read address: search key in INIT, key[mid] in WAIT, value[mid] in CMP.
    always_comb begin
        w_rd_word = '0;
        unique case (r_state)
            StInit:  w_rd_word = SkeyWord;
            StWait:  w_rd_word = {2'b00, r_mid[2:0]};
            StCmp:   w_rd_word = ValWord + {2'b00, r_mid[2:0]};
            default: w_rd_word = '0;
        endcase
    end

    // Search FSM with index datapath and registered done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_lo       <= '0;
            r_hi       <= '0;
            r_mid      <= '0;
            r_skey     <= '0;
            r_key_mid  <= '0;
            r_res_word <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_port) begin
                        r_state <= StInit;
                    end
                end
                StInit: begin
                    r_lo    <= 5'sd0;
                    r_hi    <= 5'(Depth - 1);
                    r_skey  <= w_rd_data;
                    r_state <= StReq;
                end
                StReq: begin
                    r_mid   <= w_mid;
                    r_state <= StWait;
                end
                StWait: begin
                    r_key_mid <= w_rd_data;
                    r_state   <= StCmp;
                end
                StCmp: begin
                    if (w_key_eq) begin
                        r_res_word <= w_rd_data;
                        r_state    <= StWr;
                    end else begin
                        r_lo <= w_lo_nxt;
                        r_hi <= w_hi_nxt;
                        if (w_miss) begin
                            r_res_word <= MissWord;
                            r_state    <= StWr;
                        end else begin
                            r_state <= StReq;
                        end
                    end
                end
                StWr: begin
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign done_port = r_done;

    bs_mem #(
        .KeyBase (MEM_var_28859_28865),
        .ValBase (MEM_var_28861_28865)
    ) u_bs_mem (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_slave_en (w_slave_en),
        .i_oe       (S_oe_ram),
        .i_we       (S_we_ram),
        .i_addr     (S_addr_ram),
        .i_wdata    (S_Wdata_ram),
        .o_rdata    (Sout_Rdata_ram),
        .o_rdy      (Sout_DataRdy),
        .i_rd_word  (w_rd_word),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_word  (ResWord),
        .i_wr_data  (r_res_word)
    );

endmodule

// File: tb/tb_binary_search_main.sv
// Scoreboard bench for binary_search_main: expectations are queued when
// stimulus is driven and checked when the DUT answers.
module tb_binary_search_main;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_port;
    logic [1:0]  S_oe_ram;
    logic [1:0]  S_we_ram;
    logic [13:0] S_addr_ram;
    logic [15:0] S_Wdata_ram;
    logic [7:0]  S_data_ram_size;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mdl [128];
    int         n_checks = 0;
    int         n_errors = 0;

    binary_search_main dut (
        .clock           (clock),
        .reset           (reset),
        .start_port      (start_port),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .done_port       (done_port),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_word(input int addr, input logic [31:0] w);
        for (int b = 0; b < 4; b++) mdl[addr + b] = w[8*b +: 8];
    endtask

    // Default memory image: keys 10..80, values 100..107, search key 50, result 0.
    task automatic model_reset();
        for (int a = 0; a < 128; a++) mdl[a] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            model_word(32 + 4 * i, 32'(10 * (i + 1)));
            model_word(64 + 4 * i, 32'(100 + i));
        end
        model_word(96, 32'd50);
    endtask

    function automatic bit mapped(input int a);
        return a >= 32 && a < 104;
    endfunction

    task automatic write2(input logic [1:0] mask, input int a0, input logic [7:0] d0,
                          input int a1, input logic [7:0] d1);
        exp_t e;
        sb_q.push_back('{"wr_rdy", 32'(mask)});
        if (mask[0] && mapped(a0)) mdl[a0] = d0;
        if (mask[1] && mapped(a1)) mdl[a1] = d1;
        S_we_ram    = mask;
        S_addr_ram  = {7'(a1), 7'(a0)};
        S_Wdata_ram = {d1, d0};
        tick();
        S_we_ram = 2'b00;
        tick();
        e = sb_q.pop_front();
        check(e.tag, 32'(Sout_DataRdy), e.val);
    endtask

    task automatic read2(input int a0, input int a1);
        exp_t e;
        sb_q.push_back('{"rd_rdy", 32'(2'b11)});
        sb_q.push_back('{$sformatf("rd_ch0_a%0d", a0), 32'(mdl[a0])});
        sb_q.push_back('{$sformatf("rd_ch1_a%0d", a1), 32'(mdl[a1])});
        S_oe_ram   = 2'b11;
        S_addr_ram = {7'(a1), 7'(a0)};
        tick();
        S_oe_ram = 2'b00;
        tick();
        tick();
        e = sb_q.pop_front();
        check(e.tag, 32'(Sout_DataRdy), e.val);
        e = sb_q.pop_front();
        check(e.tag, 32'(Sout_Rdata_ram[7:0]), e.val);
        e = sb_q.pop_front();
        check(e.tag, 32'(Sout_Rdata_ram[15:8]), e.val);
    endtask

    // Start a search, time the done pulse, then read the result word back.
    task automatic run_search(input int exp_cyc, input logic [31:0] exp_res, input bit poke);
        exp_t e;
        int   got;
        bit   saw_rdy;
        sb_q.push_back('{"done_cycle", 32'(exp_cyc)});
        got     = 0;
        saw_rdy = 1'b0;
        start_port = 1'b1;
        tick();
        start_port = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (poke && n == 4) begin
                S_we_ram    = 2'b01;
                S_oe_ram    = 2'b10;
                S_addr_ram  = {7'd33, 7'd96};
                S_Wdata_ram = 16'h00FF;
            end
            if (poke && n == 5) begin
                S_we_ram = 2'b00;
                S_oe_ram = 2'b00;
            end
            if (Sout_DataRdy != 2'b00) saw_rdy = 1'b1;
            if (done_port) begin
                got = n;
                break;
            end
            tick();
        end
        e = sb_q.pop_front();
        check(e.tag, 32'(got), e.val);
        tick();
        check("done_one_cycle", 32'(done_port), 32'd0);
        if (poke) check("midrun_no_rdy", 32'(saw_rdy), 32'd0);
        model_word(100, exp_res);
        read2(100, 101);
        read2(102, 103);
    endtask

    initial begin
        bit saw_done;
        reset           = 1'b1;
        start_port      = 1'b0;
        S_oe_ram        = 2'b00;
        S_we_ram        = 2'b00;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = 8'h88;
        model_reset();
        repeat (3) tick();
        check("rst_done", 32'(done_port), 32'd0);
        check("rst_rdata", 32'(Sout_Rdata_ram), 32'd0);
        check("rst_rdy", 32'(Sout_DataRdy), 32'd0);
        reset = 1'b0;
        tick();

        read2(32, 33);
        run_search(12, 32'd104, 1'b0);

        // Key 80 with a same-byte collision: channel 1 carries the real byte.
        write2(2'b11, 96, 8'h33, 96, 8'h50);
        read2(96, 97);
        run_search(15, 32'd107, 1'b0);

        write2(2'b11, 96, 8'd55, 97, 8'h00);
        run_search(12, 32'hFFFF_FFFF, 1'b0);

        write2(2'b01, 96, 8'd5, 0, 8'h00);
        run_search(12, 32'hFFFF_FFFF, 1'b0);

        write2(2'b10, 0, 8'h00, 96, 8'd10);
        run_search(12, 32'd100, 1'b1);
        read2(96, 33);

        // Unmapped write still acknowledges; unmapped reads return zero.
        write2(2'b01, 120, 8'h5A, 0, 8'h00);
        read2(120, 0);

        // Reset mid-run aborts the search and restores the image.
        start_port = 1'b1;
        tick();
        start_port = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        saw_done = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (done_port) saw_done = 1'b1;
            tick();
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        read2(96, 97);
        read2(100, 64);
        run_search(12, 32'd104, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/binary_search_main.md
# binary_search_main

Self-contained binary-search accelerator, the top-level `main` kernel of the binarysearch benchmark. It owns a small internal memory holding a sorted key table, a value table, a search key and a result word. On a start pulse it binary-searches the key table, writes the matching value (or -1) to the result word, then pulses done. A dual-channel byte slave bus gives a host preload and readback access while the kernel is idle.

## Interface
- `MEM_var_28859_28865`, default 32: byte base address of the key table, 8 × 32-bit.
- `MEM_var_28861_28865`, default 64: byte base address of the value table, 8 × 32-bit. The search key sits at this base + 32 and the result word at this base + 36.
- `clock` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start_port` in 1: start request, one cycle.
- `S_oe_ram` in 2: per-channel slave read enable.
- `S_we_ram` in 2: per-channel slave write enable.
- `S_addr_ram` in 14: per-channel 7-bit byte address; channel c uses bits [7c+6:7c].
- `S_Wdata_ram` in 16: per-channel 8-bit write data.
- `S_data_ram_size` in 8: per-channel 4-bit access size in bits. Only 8 is supported; any other value is treated as 8.
- `done_port` out 1: completion pulse.
- `Sout_Rdata_ram` out 16: per-channel 8-bit read data.
- `Sout_DataRdy` out 2: per-channel access-complete pulse.

## Operation
- Memory is byte-addressed and little-endian. All words are signed 32-bit.
- Reset contents:
  - `keys[i] = 10*(i+1)` for i = 0..7, giving 10..80.
  - `values[i] = 100+i`.
  - Search key = 50.
  - Result = 0.
- Reset restores these contents and aborts any run in progress.
- Search FSM:
  - IDLE: waits for `start_port`; then goes to INIT.
  - INIT: lo = 0, hi = 7, using signed 5-bit indices.
  - REQ: mid = (lo+hi)>>>1 (arithmetic shift); issue an internal read of `keys[mid]`.
  - WAIT.
  - CMP: signed compare of `keys[mid]` with the search key.
    - Equal → latch `values[mid]`, go to WR.
    - Key < search key → lo = mid+1.
    - Otherwise → hi = mid−1.
    - After either update: if lo > hi, latch 0xFFFFFFFF and go to WR; else go to REQ.
  - WR: write the latched word to the result.
  - DONE: assert `done_port`, then return to IDLE.
- `start_port` is ignored outside IDLE.
- Slave bus rules:
  - Slave accesses are serviced only in IDLE. Accesses in other states are dropped and produce no `Sout_DataRdy`.
  - Both channels may access in the same cycle.
  - If both channels write the same byte in one cycle, channel 1 wins.
  - Reads of addresses outside the mapped region return 0.
  - Writes outside the mapped region are ignored, but still return a ready pulse.

## Timing
- Outputs under reset: `done_port` = 0, `Sout_Rdata_ram` = 0, `Sout_DataRdy` = 0.
- `start_port` is sampled at edge E0.
- `done_port` is high for exactly one cycle: cycle 3k+3 after E0, where k is the number of compare iterations.
- The result word is updated at the edge that begins the DONE cycle, so it is readable once the FSM is back in IDLE.
- Slave read: `oe[c]` is sampled at edge T. At edge T+2, `Sout_Rdata_ram[8c+7:8c]` carries the byte and `Sout_DataRdy[c]` pulses high for one cycle. Read data is held until the next read completes.
- Slave write: `we[c]` is sampled at edge T; the byte is written at T. `Sout_DataRdy[c]` pulses during the cycle after T+1.
- If `oe` and `we` are both asserted on one channel, the write takes precedence.

## Structure
- Shared package contents:
  - FSM state enum.
  - Table depth (8).
  - Word width (32).
  - Reset-content constants.
  - Key and result offsets.
- One sub-module, `bs_mem`:
  - Register-based byte memory.
  - Two slave ports with the read delay pipeline.
  - One internal 32-bit read port and one internal 32-bit write port.
- The FSM and index datapath live in the top module.

## Test plan
- Reset, then start with the default key 50 → 3 iterations; `done_port` in cycle 12 after start; result reads back 104 (bytes 0x68, 0, 0, 0 at addresses 100–103).
- Preload key 80 via slave writes at addresses 96–99, then start → 4 iterations; done in cycle 15; result 107.
- Key 55 → miss after 3 iterations; done in cycle 12; result 0xFFFFFFFF.
- Key 5 → miss, hi goes to −1; result 0xFFFFFFFF. Key 10 → result 100 after 3 iterations.
- Dual-channel slave read of addresses 32 and 33 → `Sout_Rdata_ram` = {0x00, 0x0A} with `Sout_DataRdy` = 2'b11 two edges later. Slave access issued mid-search → no `Sout_DataRdy`.
- Reset asserted mid-search → `done_port` never pulses; memories return to defaults; the next start yields result 104.
